branch_target_predictor: RTL and testbench

//   Next-PC generator that sits directly upstream of the PC register and drives its pc_i.

---
 rtl/branch_target_predictor_if.sv | 29 ++
 rtl/branch_target_predictor.sv | 105 ++++++++++
 tb/tb_branch_target_predictor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Purpose: bundles the fetch-side lookup and EX-side training signals of the
//          branch target predictor.
// Ports (signal summary):
//   pc_i / pred_pc_o / pred_taken_o      : fetch lookup (combinational)
//   upd_valid_i .. upd_mispredict_i      : resolved-branch training bus from EX
//   br_cnt_o / mis_cnt_o                 : performance counters
// master = the surrounding pipeline, slave = the predictor.
interface branch_target_predictor_if;
    logic [31:0] pc_i;
    logic [31:0] pred_pc_o;
    logic        pred_taken_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;
    logic [31:0] br_cnt_o;
    logic [31:0] mis_cnt_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispredict_i,
        input  pred_pc_o, pred_taken_o, br_cnt_o, mis_cnt_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispredict_i,
        output pred_pc_o, pred_taken_o, br_cnt_o, mis_cnt_o
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Purpose: next-PC generator. Direct-mapped flop-based BTB with 2-bit saturating
//          counters; combinational lookup of pc_i, one-cycle training from EX,
//          saturating resolved-branch / mispredict counters.
// Ports:
//   clk_i : clock, all state updates on posedge
//   rst_i : synchronous active-high reset
//   bus   : branch_target_predictor_if.slave (lookup, training, perf counters)
module branch_target_predictor #(
    parameter int unsigned IDX_W = 4
) (
    input logic                        clk_i,
    input logic                        rst_i,
    branch_target_predictor_if.slave   bus
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [31:0]       target_d [ENTRIES];
    logic [1:0]        ctr_d    [ENTRIES];

    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    // PC bits [1:0] take no part in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_i[1:0], bus.upd_pc_i[1:0]};

    assign lk_idx = bus.pc_i[IDX_W+1:2];
    assign lk_tag = bus.pc_i[31:IDX_W+2];
    assign up_idx = bus.upd_pc_i[IDX_W+1:2];
    assign up_tag = bus.upd_pc_i[31:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bus.pred_taken_o = lk_hit && ctr_q[lk_idx][1];
        bus.pred_pc_o    = bus.pred_taken_o ? target_q[lk_idx] : bus.pc_i + 32'd4;
    end

    // Table training and perf counter next-state.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

        if (bus.upd_valid_i) begin
            if (up_hit) begin
                if (bus.upd_taken_i) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    target_d[up_idx] = bus.upd_target_i;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (bus.upd_taken_i) begin
                // Allocate weakly-taken, evicting whatever aliased here.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target_i;
                ctr_d[up_idx]    = 2'b10;
            end

            if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
            if (bus.upd_mispredict_i && (mis_cnt_q != 32'hFFFF_FFFF))
                mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    // State registers; reset wins over a coincident update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.br_cnt_o  = br_cnt_q;
    assign bus.mis_cnt_o = mis_cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Purpose: scoreboard bench for branch_target_predictor. Stimulus pushes the
//          expected lookup/counter values for each cycle; a negedge monitor pops
//          and compares them against the DUT.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_predictor_if bus ();

    branch_target_predictor #(.IDX_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    bit   stim_done = 1'b0;

    task automatic chk32(input int id, input string what, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL chk%0d %s: got 0x%08h expected 0x%08h", id, what, act, req);
        end
    endtask

    // Monitor: compares the DUT outputs presented in each cycle with the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk32(e.id, "pred_pc", bus.pred_pc_o, e.pc);
            chk32(e.id, "pred_taken", {31'd0, bus.pred_taken_o}, {31'd0, e.taken});
            chk32(e.id, "br_cnt", bus.br_cnt_o, e.br);
            chk32(e.id, "mis_cnt", bus.mis_cnt_o, e.mis);
        end
    end

    int cyc_id = 0;

    // One cycle: drive inputs, queue what the lookup and counters must show this cycle.
    task automatic cyc(input logic r, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um,
                       input logic [31:0] epc, input logic et,
                       input logic [31:0] ebr, input logic [31:0] emis);
        exp_t e;
        rst                  = r;
        bus.pc_i             = pc;
        bus.upd_valid_i      = uv;
        bus.upd_pc_i         = upc;
        bus.upd_taken_i      = ut;
        bus.upd_target_i     = utgt;
        bus.upd_mispredict_i = um;
        cyc_id++;
        e.id = cyc_id; e.pc = epc; e.taken = et; e.br = ebr; e.mis = emis;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pc_i = 32'h100; bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0;
        bus.upd_taken_i = 1'b0; bus.upd_target_i = '0; bus.upd_mispredict_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //    rst pc             uv upc            ut tgt           um  exp_pc        t  br  mis
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h104,      0, 0,  0);  // empty table
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 1,  32'h104,      0, 0,  0);  // allocate
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h200,      1, 1,  1);  // ctr 10
        cyc(0, 32'h100,        1, 32'h100,      0, 32'h0,   1,  32'h200,      1, 1,  1);  // ->01
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h104,      0, 2,  2);
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 1,  32'h104,      0, 2,  2);  // ->10
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h200,      1, 3,  3);
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 0,  32'h200,      1, 3,  3);  // ->11
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 0,  32'h200,      1, 4,  3);  // sat 11
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 0,  32'h200,      1, 5,  3);  // sat 11
        cyc(0, 32'h100,        1, 32'h100,      0, 32'h0,   0,  32'h200,      1, 6,  3);  // ->10
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h200,      1, 7,  3);  // still taken
        cyc(0, 32'h140,        0, 32'h0,        0, 32'h0,   0,  32'h144,      0, 7,  3);  // alias miss
        cyc(0, 32'h140,        1, 32'h140,      1, 32'h300, 1,  32'h144,      0, 7,  3);  // evict
        cyc(0, 32'h140,        0, 32'h0,        0, 32'h0,   0,  32'h300,      1, 8,  4);
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h104,      0, 8,  4);  // evicted
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h200, 1,  32'h104,      0, 8,  4);  // realloc 10
        cyc(0, 32'h100,        1, 32'h100,      1, 32'h280, 0,  32'h200,      1, 9,  5);  // no bypass
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h280,      1, 10, 5);  // new target
        cyc(0, 32'hFFFF_FFFC,  0, 32'h0,        0, 32'h0,   0,  32'h0,        0, 10, 5);  // wrap
        cyc(0, 32'h180,        1, 32'h180,      0, 32'h0,   0,  32'h184,      0, 10, 5);  // miss NT
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h280,      1, 11, 5);  // untouched
        cyc(1, 32'h100,        1, 32'h100,      1, 32'h500, 1,  32'h280,      1, 11, 5);  // reset+upd
        cyc(0, 32'h100,        0, 32'h0,        0, 32'h0,   0,  32'h104,      0, 0,  0);  // cleared
        cyc(0, 32'h140,        0, 32'h0,        0, 32'h0,   0,  32'h144,      0, 0,  0);
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
